// File: rtl/fpu_sequencer.sv
// One-request-at-a-time bridge between the execute stage and the FPU controller.
// Latches a request, runs the operand/result strobe-ack handshakes and returns the result.
module fpu_sequencer #(
  parameter int         CNT_W  = 16,
  parameter logic [3:0] MAX_OP = 4'b1010
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic             resp_err,
  output logic [CNT_W-1:0] resp_cycles,
  output logic [3:0]       fpu_op,
  output logic [31:0]      fpu_in1,
  output logic [31:0]      fpu_in2,
  output logic             fpu_in1_stb,
  output logic             fpu_in2_stb,
  input  logic             fpu_in1_ack,
  input  logic             fpu_in2_ack,
  input  logic [31:0]      fpu_out,
  input  logic             fpu_out_stb,
  output logic             fpu_out_ack
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t            state_reg, state_next;
  logic              req_ready_reg, req_ready_next;
  logic              resp_valid_reg, resp_valid_next;
  logic [31:0]       resp_data_reg, resp_data_next;
  logic              resp_err_reg, resp_err_next;
  logic [CNT_W-1:0]  resp_cycles_reg, resp_cycles_next;
  logic [3:0]        fpu_op_reg, fpu_op_next;
  logic [31:0]       fpu_in1_reg, fpu_in1_next;
  logic [31:0]       fpu_in2_reg, fpu_in2_next;
  logic              in1_stb_reg, in1_stb_next;
  logic              in2_stb_reg, in2_stb_next;
  logic              out_ack_reg, out_ack_next;
  logic              sent1_reg, sent1_next;
  logic              sent2_reg, sent2_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              xfer1, xfer2, xfer_out;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign xfer1    = in1_stb_reg && fpu_in1_ack;
  assign xfer2    = in2_stb_reg && fpu_in2_ack;
  assign xfer_out = out_ack_reg && fpu_out_stb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      req_ready_reg   <= 1'b1;
      resp_valid_reg  <= 1'b0;
      resp_data_reg   <= '0;
      resp_err_reg    <= 1'b0;
      resp_cycles_reg <= '0;
      fpu_op_reg      <= '0;
      fpu_in1_reg     <= '0;
      fpu_in2_reg     <= '0;
      in1_stb_reg     <= 1'b0;
      in2_stb_reg     <= 1'b0;
      out_ack_reg     <= 1'b0;
      sent1_reg       <= 1'b0;
      sent2_reg       <= 1'b0;
      cnt_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      req_ready_reg   <= req_ready_next;
      resp_valid_reg  <= resp_valid_next;
      resp_data_reg   <= resp_data_next;
      resp_err_reg    <= resp_err_next;
      resp_cycles_reg <= resp_cycles_next;
      fpu_op_reg      <= fpu_op_next;
      fpu_in1_reg     <= fpu_in1_next;
      fpu_in2_reg     <= fpu_in2_next;
      in1_stb_reg     <= in1_stb_next;
      in2_stb_reg     <= in2_stb_next;
      out_ack_reg     <= out_ack_next;
      sent1_reg       <= sent1_next;
      sent2_reg       <= sent2_next;
      cnt_reg         <= cnt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    req_ready_next   = req_ready_reg;
    resp_valid_next  = resp_valid_reg;
    resp_data_next   = resp_data_reg;
    resp_err_next    = resp_err_reg;
    resp_cycles_next = resp_cycles_reg;
    fpu_op_next      = fpu_op_reg;
    fpu_in1_next     = fpu_in1_reg;
    fpu_in2_next     = fpu_in2_reg;
    in1_stb_next     = in1_stb_reg;
    in2_stb_next     = in2_stb_reg;
    out_ack_next     = out_ack_reg;
    sent1_next       = sent1_reg;
    sent2_next       = sent2_reg;
    cnt_next         = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid && req_ready_reg) begin
          req_ready_next = 1'b0;
          if (req_op <= MAX_OP) begin
            fpu_op_next  = req_op;
            fpu_in1_next = req_a;
            fpu_in2_next = req_b;
            in1_stb_next = 1'b1;
            in2_stb_next = 1'b1;
            sent1_next   = 1'b0;
            sent2_next   = 1'b0;
            cnt_next     = '0;
            state_next   = SEND;
          end else begin
            // Illegal op never reaches the FPU; answer directly.
            resp_err_next    = 1'b1;
            resp_data_next   = '0;
            resp_cycles_next = '0;
            resp_valid_next  = 1'b1;
            state_next       = RESP;
          end
        end
      end
      SEND: begin
        cnt_next = sat_inc(cnt_reg);
        if (xfer1) begin
          in1_stb_next = 1'b0;
          sent1_next   = 1'b1;
        end
        if (xfer2) begin
          in2_stb_next = 1'b0;
          sent2_next   = 1'b1;
        end
        if ((sent1_reg || xfer1) && (sent2_reg || xfer2)) begin
          out_ack_next = 1'b1;
          state_next   = WAIT;
        end
      end
      WAIT: begin
        cnt_next = sat_inc(cnt_reg);
        if (xfer_out) begin
          resp_data_next   = fpu_out;
          resp_err_next    = 1'b0;
          resp_cycles_next = sat_inc(cnt_reg);
          out_ack_next     = 1'b0;
          resp_valid_next  = 1'b1;
          state_next       = RESP;
        end
      end
      RESP: begin
        if (resp_valid_reg && resp_ready) begin
          resp_valid_next = 1'b0;
          req_ready_next  = 1'b1;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready   = req_ready_reg;
  assign resp_valid  = resp_valid_reg;
  assign resp_data   = resp_data_reg;
  assign resp_err    = resp_err_reg;
  assign resp_cycles = resp_cycles_reg;
  assign fpu_op      = fpu_op_reg;
  assign fpu_in1     = fpu_in1_reg;
  assign fpu_in2     = fpu_in2_reg;
  assign fpu_in1_stb = in1_stb_reg;
  assign fpu_in2_stb = in2_stb_reg;
  assign fpu_out_ack = out_ack_reg;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Bench for fpu_sequencer: directed requests, a scripted FPU responder and a
// scoreboard monitor that compares every consumed response against queued expectations.
module tb_fpu_sequencer;

  logic        clk, reset_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [15:0] resp_cycles;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_in1, fpu_in2;
  logic        fpu_in1_stb, fpu_in2_stb, fpu_in1_ack, fpu_in2_ack;
  logic [31:0] fpu_out;
  logic        fpu_out_stb, fpu_out_ack;

  fpu_sequencer #(.CNT_W(16), .MAX_OP(4'b1010)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .resp_cycles(resp_cycles),
    .fpu_op(fpu_op), .fpu_in1(fpu_in1), .fpu_in2(fpu_in2),
    .fpu_in1_stb(fpu_in1_stb), .fpu_in2_stb(fpu_in2_stb),
    .fpu_in1_ack(fpu_in1_ack), .fpu_in2_ack(fpu_in2_ack),
    .fpu_out(fpu_out), .fpu_out_stb(fpu_out_stb), .fpu_out_ack(fpu_out_ack)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [15:0] cycles;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Scripted FPU behaviour for the current op
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b, m_res;
  int          m_d1, m_d2, m_rd;
  int          n1, n2, stb_viol;
  bit          watch_quiet, watch_op;
  int          quiet_viol, op_viol;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run not finished, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic e, input logic [15:0] c);
    exp_t x;
    x.data = d; x.err = e; x.cycles = c;
    sb.push_back(x);
  endtask

  task automatic start_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input int d1, input int d2, input int rd);
    m_op = op; m_a = a; m_b = b; m_res = res;
    m_d1 = d1; m_d2 = d2; m_rd = rd;
    n1 = 0; n2 = 0;
    req_op = op; req_a = a; req_b = b;
    req_valid = 1;
  endtask

  task automatic wait_accept();
    bit ok;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      ok = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 0;
    check("accept", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && req_ready) ok = 1;
    end
    check("idle_reached", ok, 1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && resp_valid && resp_ready) begin
      check("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_t x;
        x = sb.pop_front();
        $display("resp data=%h err=%0d cycles=%0d (exp %h/%0d/%0d)",
                 resp_data, resp_err, resp_cycles, x.data, x.err, x.cycles);
        check("resp_data", resp_data, x.data);
        check("resp_err", resp_err, x.err);
        check("resp_cycles", resp_cycles, x.cycles);
      end
    end
  end

  always @(negedge clk) begin
    if (watch_quiet && (fpu_in1_stb || fpu_in2_stb || fpu_out_ack)) quiet_viol++;
    if (watch_op && fpu_op != 4'b0001) op_viol++;
  end

  // FPU responder: snapshot before each edge, react #1 after it
  initial begin
    bit s1, s2, so, got1, got2;
    logic [3:0]  s_op;
    logic [31:0] s_in1, s_in2;
    int w1, w2, rw;
    fpu_in1_ack = 0; fpu_in2_ack = 0; fpu_out_stb = 0; fpu_out = 0;
    got1 = 0; got2 = 0; w1 = 0; w2 = 0; rw = 0;
    forever begin
      @(negedge clk);
      s1 = fpu_in1_stb && fpu_in1_ack;
      s2 = fpu_in2_stb && fpu_in2_ack;
      so = fpu_out_stb && fpu_out_ack;
      s_op = fpu_op; s_in1 = fpu_in1; s_in2 = fpu_in2;
      @(posedge clk); #1;
      if (!reset_n) begin
        fpu_in1_ack = 0; fpu_in2_ack = 0; fpu_out_stb = 0;
        got1 = 0; got2 = 0; w1 = 0; w2 = 0; rw = 0;
      end else begin
        if (s1) begin
          n1++; got1 = 1; fpu_in1_ack = 0;
          check("fpu_in1", s_in1, m_a);
          check("fpu_op_in1", s_op, m_op);
        end
        if (s2) begin
          n2++; got2 = 1; fpu_in2_ack = 0;
          check("fpu_in2", s_in2, m_b);
        end
        if (so) begin
          fpu_out_stb = 0;
          got1 = 0; got2 = 0; w1 = 0; w2 = 0; rw = 0;
        end else if (got1 && got2 && !fpu_out_stb) begin
          if (rw >= m_rd) begin
            fpu_out_stb = 1;
            fpu_out = m_res;
          end else rw++;
        end
        if (!got1 && fpu_in1_stb && !fpu_in1_ack) begin
          if (w1 >= m_d1) fpu_in1_ack = 1; else w1++;
        end
        if (!got2 && fpu_in2_stb && !fpu_in2_ack) begin
          if (w2 >= m_d2) fpu_in2_ack = 1; else w2++;
        end
        if ((got1 && fpu_in1_stb) || (got2 && fpu_in2_stb)) stb_viol++;
      end
    end
  end

  initial begin
    reset_n = 0; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; resp_ready = 1;
    m_op = 0; m_a = 0; m_b = 0; m_res = 0; m_d1 = 0; m_d2 = 0; m_rd = 0;
    n1 = 0; n2 = 0; stb_viol = 0; quiet_viol = 0; op_viol = 0;
    watch_quiet = 0; watch_op = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_handshakes", {fpu_in1_stb, fpu_in2_stb, fpu_out_ack}, 0);
    check("rst_fpu_bus", {fpu_op, fpu_in1, fpu_in2}, 0);
    check("rst_resp", {resp_data, resp_err, resp_cycles}, 0);
    reset_n = 1;

    // fadd 1.0 + 2.0, operand 2 acked 2 cycles late, result after 3 more: 3 SEND + 4 WAIT
    start_req(4'b0000, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 2, 3);
    push_exp(32'h40400000, 1'b0, 16'd7);
    wait_accept();
    wait_idle();
    check("fadd_in1_xfers", n1, 1);
    check("fadd_in2_xfers", n2, 1);

    // fsub 3.0 - 1.0, fpu_op must hold 0001 until consume
    start_req(4'b0001, 32'h40400000, 32'h3F800000, 32'h40000000, 1, 0, 1);
    push_exp(32'h40000000, 1'b0, 16'd4);
    wait_accept();
    watch_op = 1;
    wait_idle();
    watch_op = 0;
    check("fsub_op_held", op_viol, 0);

    // fsgnjn: combinational, resp_valid on the third edge counting the accept edge
    start_req(4'b0111, 32'h3F800000, 32'h3F800000, 32'hBF800000, 0, 0, 0);
    push_exp(32'hBF800000, 1'b0, 16'd2);
    wait_accept();
    check("fsgnjn_valid_e1", resp_valid, 0);
    @(posedge clk); #1;
    check("fsgnjn_valid_e2", resp_valid, 0);
    @(posedge clk); #1;
    check("fsgnjn_valid_e3", resp_valid, 1);
    wait_idle();

    // fle -1.0 <= 1.0
    start_req(4'b1010, 32'hBF800000, 32'h3F800000, 32'h00000001, 0, 0, 0);
    push_exp(32'h00000001, 1'b0, 16'd2);
    wait_accept();
    wait_idle();

    // Illegal op: answered on the accept edge, FPU never strobed
    watch_quiet = 1;
    start_req(4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'hDEADBEEF, 0, 0, 0);
    push_exp(32'h00000000, 1'b1, 16'd0);
    wait_accept();
    check("illegal_valid_e1", resp_valid, 1);
    wait_idle();
    repeat (2) @(negedge clk);
    watch_quiet = 0;
    check("illegal_quiet", quiet_viol, 0);

    // Backpressure: fmul 2.0 * 3.0 held for 5 cycles, next request pending
    resp_ready = 0;
    start_req(4'b0010, 32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 1);
    push_exp(32'h40C00000, 1'b0, 16'd3);
    wait_accept();
    begin
      bit seen;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        seen = resp_valid;
      end
      check("bp_resp_seen", seen, 1);
    end
    start_req(4'b0110, 32'h40000000, 32'hBF800000, 32'hC0000000, 0, 0, 0);
    push_exp(32'hC0000000, 1'b0, 16'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_data_stable", resp_data, 32'h40C00000);
      check("bp_req_ready_low", req_ready, 0);
    end
    @(posedge clk); #1;
    resp_ready = 1;
    @(negedge clk);
    check("bp_ready_before_consume", req_ready, 0);
    @(negedge clk);
    check("bp_ready_after_consume", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    check("bp_pending_accepted", req_ready, 0);
    wait_idle();

    // Reset during WAIT of fdiv 1.0 / 3.0
    start_req(4'b0011, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 0, 0, 20);
    wait_accept();
    begin
      bit in_wait;
      in_wait = 0;
      for (int k = 0; k < 20 && !in_wait; k++) begin
        @(negedge clk);
        in_wait = fpu_out_ack;
      end
      check("fdiv_reached_wait", in_wait, 1);
    end
    #2 reset_n = 0;
    #1;
    check("arst_req_ready", req_ready, 1);
    check("arst_resp_valid", resp_valid, 0);
    check("arst_handshakes", {fpu_in1_stb, fpu_in2_stb, fpu_out_ack}, 0);
    check("arst_fpu_bus", {fpu_op, fpu_in1, fpu_in2}, 0);
    check("arst_resp", {resp_data, resp_err, resp_cycles}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;

    // fcvt.s.w 5 -> 5.0 after reset
    start_req(4'b0101, 32'h00000005, 32'h00000000, 32'h40A00000, 0, 0, 2);
    push_exp(32'h40A00000, 1'b0, 16'd4);
    wait_accept();
    wait_idle();

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("stb_after_transfer", stb_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
